// File: rtl/reset_sequencer.sv
// Reset sequencer: filters synchronous reset requests, then holds every domain in reset
// and releases the domains one at a time in ascending order, recording what caused the reset.
module reset_sequencer #(
  parameter int NUM_SRC        = 2,
  parameter int NUM_DOM        = 3,
  parameter int FILTER_CYCLES  = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] req_i,
  output logic [NUM_DOM-1:0] dom_rst_n_o,
  output logic               busy_o,
  output logic [NUM_SRC:0]   cause_o
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);

  localparam logic [NUM_DOM-1:0] DOM_FIRST = NUM_DOM'(1);
  localparam logic [NUM_SRC:0]   CAUSE_POR = {{NUM_SRC{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [FW-1:0]      r_filt [NUM_SRC];
  logic [NUM_SRC-1:0] r_qual;

  state_t             r_state;
  logic [HW-1:0]      r_hold;
  logic [SW-1:0]      r_stag;
  logic [NUM_DOM-1:0] r_dom;
  logic               r_busy;
  logic [NUM_SRC:0]   r_cause;

  logic               w_any_qual;
  logic [NUM_DOM-1:0] w_dom_next;

  assign w_any_qual = |r_qual;
  assign w_dom_next = (r_dom << 1) | DOM_FIRST;

  // qual rises on the FILTER_CYCLES-th consecutive high sample; any low sample restarts the count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_filt[i] <= '0;
      end
      r_qual <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (req_i[i]) begin
          if (r_filt[i] != FW'(FILTER_CYCLES)) begin
            r_filt[i] <= r_filt[i] + 1'b1;
          end
          r_qual[i] <= (r_filt[i] >= FW'(FILTER_CYCLES - 1));
        end else begin
          r_filt[i] <= '0;
          r_qual[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_ASSERT;
      r_hold  <= '0;
      r_stag  <= '0;
      r_dom   <= '0;
      r_busy  <= 1'b1;
      r_cause <= CAUSE_POR;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (w_any_qual) begin
            r_hold  <= '0;
            r_cause <= r_cause | {r_qual, 1'b0};
          end else if (r_hold == HW'(HOLD_CYCLES - 1)) begin
            r_hold <= '0;
            r_stag <= '0;
            r_dom  <= DOM_FIRST;
            // a single domain is fully released by its first release
            if (&DOM_FIRST) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_RELEASE;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (w_any_qual) begin
            r_state <= ST_ASSERT;
            r_hold  <= '0;
            r_stag  <= '0;
            r_dom   <= '0;
            r_busy  <= 1'b1;
            r_cause <= {r_qual, 1'b0};
          end else if (r_stag == SW'(STAGGER_CYCLES - 1)) begin
            r_stag <= '0;
            r_dom  <= w_dom_next;
            if (&w_dom_next) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
            end
          end else begin
            r_stag <= r_stag + 1'b1;
          end
        end

        ST_RUN: begin
          if (w_any_qual) begin
            r_state <= ST_ASSERT;
            r_hold  <= '0;
            r_stag  <= '0;
            r_dom   <= '0;
            r_busy  <= 1'b1;
            r_cause <= {r_qual, 1'b0};
          end
        end

        default: begin
          r_state <= ST_ASSERT;
          r_hold  <= '0;
          r_stag  <= '0;
          r_dom   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign dom_rst_n_o = r_dom;
  assign busy_o      = r_busy;
  assign cause_o     = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected output snapshots are queued with the
// edge number they belong to and compared when that edge has passed.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rst2;
  logic [1:0] req;
  logic [1:0] req2;

  logic [2:0] dom;
  logic       busy;
  logic [2:0] cause;
  logic [0:0] dom_d1;
  logic       busy_d1;
  logic [2:0] cause_d1;
  logic [2:0] dom_s1;
  logic       busy_s1;
  logic [2:0] cause_s1;

  int cyc   = 0;
  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int         cyc;
    int         sel;
    string      tag;
    logic [2:0] dom;
    logic       busy;
    logic [2:0] cause;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  logic [2:0] od;
  logic [2:0] oc;
  logic       ob;

  reset_sequencer u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .dom_rst_n_o (dom),
    .busy_o      (busy),
    .cause_o     (cause)
  );

  reset_sequencer #(.NUM_DOM(1), .HOLD_CYCLES(4)) u_d1 (
    .clk_i       (clk),
    .rst_i       (rst2),
    .req_i       (req2),
    .dom_rst_n_o (dom_d1),
    .busy_o      (busy_d1),
    .cause_o     (cause_d1)
  );

  reset_sequencer #(.STAGGER_CYCLES(1), .HOLD_CYCLES(4)) u_s1 (
    .clk_i       (clk),
    .rst_i       (rst2),
    .req_i       (req2),
    .dom_rst_n_o (dom_s1),
    .busy_o      (busy_s1),
    .cause_o     (cause_s1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, int sel, string tag, logic [2:0] d, logic b, logic [2:0] ca);
    exp_t e;
    e.cyc   = c;
    e.sel   = sel;
    e.tag   = tag;
    e.dom   = d;
    e.busy  = b;
    e.cause = ca;
    q.push_back(e);
  endfunction

  task automatic check(string tag, string fld, logic [2:0] obs, logic [2:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s.%s edge=%0d observed=%b expected=%b", tag, fld, cyc, obs, expv);
    end
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_m = q.pop_front();
      if (e_m.cyc < cyc) begin
        n_cmp++;
        n_mis++;
        $error("FAIL %s missed edge=%0d observed_edge=%0d", e_m.tag, e_m.cyc, cyc);
      end else begin
        case (e_m.sel)
          1:       begin od = {2'b00, dom_d1}; ob = busy_d1; oc = cause_d1; end
          2:       begin od = dom_s1;          ob = busy_s1; oc = cause_s1; end
          default: begin od = dom;             ob = busy;    oc = cause;    end
        endcase
        check(e_m.tag, "dom",   od,           e_m.dom);
        check(e_m.tag, "busy",  {2'b00, ob},  {2'b00, e_m.busy});
        check(e_m.tag, "cause", oc,           e_m.cause);
      end
    end
  end

  initial begin
    int b;
    rst  = 1'b1;
    rst2 = 1'b1;
    req  = 2'b00;
    req2 = 2'b00;

    // power-on: reset for edges 1..5, first low-reset edge is 6
    push(3,  0, "por_in_rst", 3'b000, 1'b1, 3'b001);
    push(5,  0, "por_in_rst", 3'b000, 1'b1, 3'b001);
    push(20, 0, "por_hold",   3'b000, 1'b1, 3'b001);
    push(21, 0, "por_dom0",   3'b001, 1'b1, 3'b001);
    push(28, 0, "por_stag1",  3'b001, 1'b1, 3'b001);
    push(29, 0, "por_dom1",   3'b011, 1'b1, 3'b001);
    push(36, 0, "por_stag2",  3'b011, 1'b1, 3'b001);
    push(37, 0, "por_dom2",   3'b111, 1'b0, 3'b001);
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(47);

    // three-sample pulse must be ignored
    b = cyc;
    push(b + 4, 0, "short_pulse", 3'b111, 1'b0, 3'b001);
    push(b + 6, 0, "short_pulse", 3'b111, 1'b0, 3'b001);
    req = 2'b10;
    wait_cyc(b + 3);
    req = 2'b00;
    wait_cyc(b + 10);

    // four-sample pulse on source 1, then source 0 aborts the release
    b = cyc;
    push(b + 4,  0, "req1_pre",     3'b111, 1'b0, 3'b001);
    push(b + 5,  0, "req1_assert",  3'b000, 1'b1, 3'b100);
    push(b + 20, 0, "req1_hold",    3'b000, 1'b1, 3'b100);
    push(b + 21, 0, "req1_dom0",    3'b001, 1'b1, 3'b100);
    push(b + 29, 0, "req1_dom1",    3'b011, 1'b1, 3'b100);
    push(b + 31, 0, "abort_pre",    3'b011, 1'b1, 3'b100);
    push(b + 32, 0, "abort",        3'b000, 1'b1, 3'b010);
    push(b + 47, 0, "abort_hold",   3'b000, 1'b1, 3'b010);
    push(b + 48, 0, "abort_dom0",   3'b001, 1'b1, 3'b010);
    push(b + 56, 0, "abort_dom1",   3'b011, 1'b1, 3'b010);
    push(b + 63, 0, "abort_stag2",  3'b011, 1'b1, 3'b010);
    push(b + 64, 0, "abort_run",    3'b111, 1'b0, 3'b010);
    req = 2'b10;
    wait_cyc(b + 4);
    req = 2'b00;
    wait_cyc(b + 27);
    req = 2'b01;
    wait_cyc(b + 31);
    req = 2'b00;
    wait_cyc(b + 70);

    // both sources qualify together
    b = cyc;
    push(b + 4,  0, "both_pre",  3'b111, 1'b0, 3'b010);
    push(b + 5,  0, "both",      3'b000, 1'b1, 3'b110);
    push(b + 20, 0, "both_hold", 3'b000, 1'b1, 3'b110);
    push(b + 21, 0, "both_dom0", 3'b001, 1'b1, 3'b110);
    push(b + 37, 0, "both_run",  3'b111, 1'b0, 3'b110);
    req = 2'b11;
    wait_cyc(b + 4);
    req = 2'b00;
    wait_cyc(b + 40);

    // source 1 qualifies later, inside ASSERT: cause ORs in and hold restarts
    b = cyc;
    push(b + 5,  0, "late_first",  3'b000, 1'b1, 3'b010);
    push(b + 10, 0, "late_first",  3'b000, 1'b1, 3'b010);
    push(b + 11, 0, "late_or",     3'b000, 1'b1, 3'b110);
    push(b + 21, 0, "late_hold",   3'b000, 1'b1, 3'b110);
    push(b + 26, 0, "late_hold",   3'b000, 1'b1, 3'b110);
    push(b + 27, 0, "late_dom0",   3'b001, 1'b1, 3'b110);
    push(b + 43, 0, "late_run",    3'b111, 1'b0, 3'b110);
    req = 2'b01;
    wait_cyc(b + 4);
    req = 2'b00;
    wait_cyc(b + 6);
    req = 2'b10;
    wait_cyc(b + 10);
    req = 2'b00;
    wait_cyc(b + 46);

    // one-cycle reset during RUN while a request is counting
    b = cyc;
    push(b + 2,  0, "rst_pre",   3'b111, 1'b0, 3'b110);
    push(b + 3,  0, "rst_hit",   3'b000, 1'b1, 3'b001);
    push(b + 8,  0, "rst_filt",  3'b000, 1'b1, 3'b001);
    push(b + 18, 0, "rst_hold",  3'b000, 1'b1, 3'b001);
    push(b + 19, 0, "rst_dom0",  3'b001, 1'b1, 3'b001);
    push(b + 35, 0, "rst_run",   3'b111, 1'b0, 3'b001);
    req = 2'b01;
    wait_cyc(b + 2);
    rst = 1'b1;
    wait_cyc(b + 3);
    rst = 1'b0;
    wait_cyc(b + 6);
    req = 2'b00;
    wait_cyc(b + 38);

    // single-domain and one-cycle-stagger variants
    b = cyc;
    push(b + 1, 1, "d1_hold",  3'b000, 1'b1, 3'b001);
    push(b + 1, 2, "s1_hold",  3'b000, 1'b1, 3'b001);
    push(b + 3, 1, "d1_hold",  3'b000, 1'b1, 3'b001);
    push(b + 3, 2, "s1_hold",  3'b000, 1'b1, 3'b001);
    push(b + 4, 1, "d1_run",   3'b001, 1'b0, 3'b001);
    push(b + 4, 2, "s1_dom0",  3'b001, 1'b1, 3'b001);
    push(b + 5, 2, "s1_dom1",  3'b011, 1'b1, 3'b001);
    push(b + 6, 2, "s1_run",   3'b111, 1'b0, 3'b001);
    rst2 = 1'b0;
    wait_cyc(b + 9);

    while (q.size() > 0) begin
      e_m = q.pop_front();
      n_cmp++;
      n_mis++;
      $error("FAIL %s timeout edge=%0d observed_edge=%0d", e_m.tag, e_m.cyc, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
